// File: rtl/ecc_secded_dec.sv
// Pipelined Hamming SEC-DED checker/corrector with error counters and a first-DED syndrome log.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   ivld/irdy/icode       codeword input handshake (CW = DW+P+1 bits)
//   ovld/ordy             output handshake
//   odat                  corrected data (raw data bits on DED)
//   oerr_sec/oerr_ded     single-corrected / uncorrectable flags, qualified by ovld
//   osyn                  Hamming syndrome of the delivered word
//   clr_cnt               synchronous clear of counters and log
//   cnt_sec/cnt_ded       saturating counts of SEC/DED words delivered
//   log_vld/log_syn       sticky first-DED flag and its syndrome
module ecc_secded_dec #(
  parameter int unsigned DW   = 8,
  parameter int unsigned P    = 4,
  parameter int unsigned CNTW = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ivld,
  output logic            irdy,
  input  logic [DW+P:0]   icode,
  output logic            ovld,
  input  logic            ordy,
  output logic [DW-1:0]   odat,
  output logic            oerr_sec,
  output logic            oerr_ded,
  output logic [P-1:0]    osyn,
  input  logic            clr_cnt,
  output logic [CNTW-1:0] cnt_sec,
  output logic [CNTW-1:0] cnt_ded,
  output logic            log_vld,
  output logic [P-1:0]    log_syn
);

  localparam int unsigned CW = DW + P + 1;

  // P must be the smallest value covering DW data bits plus P check bits.
  if (DW < 4 || DW > 64 || (1 << P) < CW || (1 << (P - 1)) >= CW - 1) begin : g_bad_param
    $error("ecc_secded_dec: DW must be 4..64 and P the smallest value with 2**P >= DW+P+1");
  end

  // Hamming position (1-based) of data bit j: the j-th non-power-of-two position.
  function automatic int unsigned data_pos(input int unsigned j);
    int unsigned cnt;
    int unsigned pos;
    cnt = 0;
    pos = 0;
    for (int unsigned p = 1; p < CW; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (cnt == j) pos = p;
        cnt++;
      end
    end
    return pos;
  endfunction

  logic          s1_vld;
  logic [CW-1:0] s1_code;
  logic [P-1:0]  s1_syn;
  logic          s1_g;
  logic          s2_adv;
  logic          ohs;
  logic [P-1:0]  syn_c;
  logic          g_c;
  logic [CW-1:0] fix_c;
  logic [DW-1:0] dat_c;
  logic          sec_c;
  logic          ded_c;

  assign s2_adv = ~ovld | ordy;
  assign irdy   = ~s1_vld | s2_adv;
  assign ohs    = ovld & ordy;

  // Syndrome and overall parity of the incoming word.
  always_comb begin
    syn_c = '0;
    for (int unsigned i = 0; i < CW - 1; i++) begin
      for (int unsigned k = 0; k < P; k++) begin
        if ((((i + 1) >> k) & 1) != 0) syn_c[k] = syn_c[k] ^ icode[i];
      end
    end
    g_c = ^icode;
  end

  // Classify, correct the flagged position, extract data.
  always_comb begin
    fix_c = s1_code;
    sec_c = 1'b0;
    ded_c = 1'b0;
    if (s1_g && (32'(s1_syn) <= CW - 1)) begin
      sec_c = 1'b1;
      for (int unsigned i = 0; i < CW - 1; i++) begin
        if (32'(s1_syn) == i + 1) fix_c[i] = ~fix_c[i];
      end
    end else if (s1_g || (s1_syn != '0)) begin
      ded_c = 1'b1;
    end
    dat_c = '0;
    for (int unsigned j = 0; j < DW; j++) begin
      dat_c[j] = fix_c[data_pos(j) - 1];
    end
  end

  // Stage 1: codeword, syndrome, parity.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld  <= 1'b0;
      s1_code <= '0;
      s1_syn  <= '0;
      s1_g    <= 1'b0;
    end else if (irdy) begin
      s1_vld <= ivld;
      if (ivld) begin
        s1_code <= icode;
        s1_syn  <= syn_c;
        s1_g    <= g_c;
      end
    end
  end

  // Stage 2: corrected data and flags, held while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovld     <= 1'b0;
      odat     <= '0;
      oerr_sec <= 1'b0;
      oerr_ded <= 1'b0;
      osyn     <= '0;
    end else if (s2_adv) begin
      ovld <= s1_vld;
      if (s1_vld) begin
        odat     <= dat_c;
        oerr_sec <= sec_c;
        oerr_ded <= ded_c;
        osyn     <= s1_syn;
      end
    end
  end

  // Saturating counters; a clear coinciding with an increment leaves 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_sec <= '0;
      cnt_ded <= '0;
    end else begin
      if (clr_cnt) cnt_sec <= (ohs && oerr_sec) ? CNTW'(1) : '0;
      else if (ohs && oerr_sec && (cnt_sec != '1)) cnt_sec <= cnt_sec + CNTW'(1);
      if (clr_cnt) cnt_ded <= (ohs && oerr_ded) ? CNTW'(1) : '0;
      else if (ohs && oerr_ded && (cnt_ded != '1)) cnt_ded <= cnt_ded + CNTW'(1);
    end
  end

  // First-DED log; a clear coinciding with a DED captures the new one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      log_vld <= 1'b0;
      log_syn <= '0;
    end else if (clr_cnt) begin
      log_vld <= ohs & oerr_ded;
      log_syn <= (ohs && oerr_ded) ? osyn : '0;
    end else if (ohs && oerr_ded && !log_vld) begin
      log_vld <= 1'b1;
      log_syn <= osyn;
    end
  end

endmodule

// File: tb/tb_ecc_secded_dec.sv
// Self-checking bench for ecc_secded_dec (DW=8, P=4, CW=13, CNTW=4).
module tb_ecc_secded_dec;

  typedef struct {
    logic [7:0] dat;
    logic       sec;
    logic       ded;
    logic [3:0] syn;
    int         acc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ivld;
  logic        irdy;
  logic [12:0] icode;
  logic        ovld;
  logic        ordy;
  logic [7:0]  odat;
  logic        oerr_sec;
  logic        oerr_ded;
  logic [3:0]  osyn;
  logic        clr_cnt;
  logic [3:0]  cnt_sec;
  logic [3:0]  cnt_ded;
  logic        log_vld;
  logic [3:0]  log_syn;

  ecc_secded_dec #(.DW(8), .P(4), .CNTW(4)) dut (
    .clk(clk), .rst_n(rst_n), .ivld(ivld), .irdy(irdy), .icode(icode),
    .ovld(ovld), .ordy(ordy), .odat(odat), .oerr_sec(oerr_sec), .oerr_ded(oerr_ded),
    .osyn(osyn), .clr_cnt(clr_cnt), .cnt_sec(cnt_sec), .cnt_ded(cnt_ded),
    .log_vld(log_vld), .log_syn(log_syn)
  );

  always #5 clk = ~clk;

  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   n_acc = 0;
  bit   chk_lat = 0;
  bit   chk_irdy1 = 0;
  bit   rnd_on = 0;
  exp_t q[$];
  int   dpos[8] = '{3, 5, 6, 7, 9, 10, 11, 12};

  int         m_sec = 0;
  int         m_ded = 0;
  bit         m_lv = 0;
  logic [3:0] m_ls = '0;
  bit         held = 0;
  logic [7:0] h_dat;
  logic       h_sec;
  logic       h_ded;
  logic [3:0] h_syn;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic [7:0] d, input logic s, input logic e, input logic [3:0] sy);
    exp_t r;
    r.dat = d; r.sec = s; r.ded = e; r.syn = sy; r.acc = 0;
    return r;
  endfunction

  // Encode d, flip the bits in mask, and predict the decoder outcome from the flipped positions.
  function automatic void model(input logic [7:0] d, input logic [12:0] mask,
                                output logic [12:0] code, output exp_t e);
    logic [12:0] w;
    logic [12:0] fixed;
    logic        par;
    int          s;
    int          g;
    w = '0;
    for (int j = 0; j < 8; j++) w[dpos[j] - 1] = d[j];
    for (int k = 0; k < 4; k++) begin
      par = 1'b0;
      for (int p = 1; p <= 12; p++) if (((p >> k) & 1) == 1) par = par ^ w[p - 1];
      w[(1 << k) - 1] = par;
    end
    w[12] = ^w[11:0];
    code = w ^ mask;
    s = 0;
    for (int i = 0; i < 12; i++) if (mask[i]) s = s ^ (i + 1);
    g = $countones(mask) % 2;
    fixed = code;
    e = mk(8'h00, 1'b0, 1'b0, 4'(s));
    if (g == 1 && s <= 12) begin
      e.sec = 1'b1;
      if (s != 0) fixed[s - 1] = ~fixed[s - 1];
    end else if (g == 1 || s != 0) begin
      e.ded = 1'b1;
    end
    for (int j = 0; j < 8; j++) e.dat[j] = fixed[dpos[j] - 1];
  endfunction

  function automatic logic [12:0] rmask(input int n);
    logic [12:0] m;
    m = '0;
    while ($countones(m) < n) m[$urandom_range(0, 12)] = 1'b1;
    return m;
  endfunction

  task automatic send(input logic [12:0] code, input exp_t e);
    bit done;
    int n;
    done = 0;
    n = 0;
    ivld = 1'b1;
    icode = code;
    while (!done) begin
      @(negedge clk);
      if (chk_irdy1) chk("irdy_stream", irdy, 1);
      if (irdy) begin
        e.acc = cyc;
        q.push_back(e);
        n_acc++;
        done = 1;
      end else if (++n > 200) begin
        chk("irdy_timeout", 0, 1);
        done = 1;
      end
    end
    @(posedge clk); #1;
    ivld = 1'b0;
  endtask

  task automatic send_model(input logic [7:0] d, input logic [12:0] mask);
    logic [12:0] c;
    exp_t e;
    model(d, mask, c, e);
    send(c, e);
  endtask

  task automatic drain();
    int n;
    n = 0;
    ivld = 1'b0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", 32'(q.size()), 0);
    @(posedge clk); #1;
  endtask

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    if (rnd_on) begin
      #1;
      ordy = ($urandom_range(0, 3) != 0);
    end
  end

  // Scoreboard, counter/log model and stall-stability checks.
  always @(negedge clk) begin
    exp_t e;
    bit   hs_sec;
    bit   hs_ded;
    if (!rst_n) begin
      q.delete();
      m_sec = 0; m_ded = 0; m_lv = 0; m_ls = '0; held = 0;
    end else begin
      chk("cnt_sec", 32'(cnt_sec), 32'(m_sec));
      chk("cnt_ded", 32'(cnt_ded), 32'(m_ded));
      chk("log_vld", 32'(log_vld), 32'(m_lv));
      chk("log_syn", 32'(log_syn), 32'(m_ls));
      if (held) begin
        chk("stall_ovld", 32'(ovld), 1);
        chk("stall_odat", 32'(odat), 32'(h_dat));
        chk("stall_flags", {30'd0, oerr_sec, oerr_ded}, {30'd0, h_sec, h_ded});
        chk("stall_osyn", 32'(osyn), 32'(h_syn));
      end
      hs_sec = 0;
      hs_ded = 0;
      if (ovld && ordy) begin
        if (q.size() == 0) begin
          chk("spurious_ovld", 1, 0);
        end else begin
          e = q.pop_front();
          chk("odat", 32'(odat), 32'(e.dat));
          chk("oerr_sec", 32'(oerr_sec), 32'(e.sec));
          chk("oerr_ded", 32'(oerr_ded), 32'(e.ded));
          chk("osyn", 32'(osyn), 32'(e.syn));
          if (chk_lat) chk("latency", 32'(cyc - e.acc), 2);
          hs_sec = e.sec;
          hs_ded = e.ded;
        end
      end
      if (clr_cnt) begin
        m_sec = hs_sec ? 1 : 0;
        m_ded = hs_ded ? 1 : 0;
        m_lv  = hs_ded;
        m_ls  = hs_ded ? e.syn : 4'd0;
      end else begin
        if (hs_sec && m_sec != 15) m_sec++;
        if (hs_ded && m_ded != 15) m_ded++;
        if (hs_ded && !m_lv) begin
          m_lv = 1;
          m_ls = e.syn;
        end
      end
      held  = ovld && !ordy;
      h_dat = odat; h_sec = oerr_sec; h_ded = oerr_ded; h_syn = osyn;
    end
  end

  initial begin
    int base;
    rst_n = 1'b0; ivld = 1'b0; icode = '0; ordy = 1'b1; clr_cnt = 1'b0;
    #1;
    chk("rst_ovld", 32'(ovld), 0);
    chk("rst_odat", 32'(odat), 0);
    chk("rst_cnt", {24'd0, cnt_sec, cnt_ded}, 0);
    chk("rst_log", {27'd0, log_vld, log_syn}, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Clean stream back-to-back, fixed two-cycle latency, irdy never drops.
    chk_lat = 1; chk_irdy1 = 1;
    repeat (8) send(13'h0A27, mk(8'hA5, 1'b0, 1'b0, 4'd0));
    chk_irdy1 = 0;
    drain();
    chk_lat = 0;

    // Single data-region error, parity-bit error, double error.
    send(13'h0A37, mk(8'hA5, 1'b1, 1'b0, 4'd5));
    drain();
    chk("sec_cnt_1", 32'(cnt_sec), 1);
    send(13'h1A27, mk(8'hA5, 1'b1, 1'b0, 4'd0));
    send(13'h0A24, mk(8'hA5, 1'b0, 1'b1, 4'd3));
    drain();
    chk("log_after_ded", {27'd0, log_vld, log_syn}, {27'd0, 1'b1, 4'd3});
    // Later DED does not overwrite the log.
    send_model(8'h3C, 13'b0_0000_0011_0000);
    drain();
    chk("log_sticky", 32'(log_syn), 3);

    // Back-pressure: five stall cycles mid-stream.
    base = n_acc;
    ordy = 1'b0;
    fork
      for (int i = 0; i < 6; i++) send_model(8'($urandom), '0);
      begin
        repeat (5) @(posedge clk);
        #1;
        chk("stall_accepts", 32'(n_acc - base), 2);
        chk("stall_irdy", 32'(irdy), 0);
        ordy = 1'b1;
      end
    join
    drain();

    // Random words with 0..3 flips under random back-pressure.
    rnd_on = 1;
    for (int i = 0; i < 80; i++) send_model(8'($urandom), rmask($urandom_range(0, 3)));
    // Triple flip landing outside the codeword: positions 1,2,12 -> syndrome 15.
    send_model(8'h5A, 13'b0_1000_0000_0011);
    rnd_on = 0;
    #2 ordy = 1'b1;
    drain();

    // Counter saturation and clear with coincident events.
    clr_cnt = 1'b1;
    @(posedge clk); #1;
    clr_cnt = 1'b0;
    chk("clr_alone", {24'd0, cnt_sec, cnt_ded}, 0);
    for (int i = 0; i < 15; i++) send_model(8'($urandom), rmask(1));
    drain();
    chk("sec_at_15", 32'(cnt_sec), 15);
    for (int i = 0; i < 3; i++) send_model(8'($urandom), rmask(1));
    drain();
    chk("sec_saturated", 32'(cnt_sec), 15);
    send_model(8'h81, 13'b0_0000_0100_0000);
    @(posedge clk); #1;
    clr_cnt = 1'b1;
    @(posedge clk); #1;
    clr_cnt = 1'b0;
    chk("clr_with_sec", 32'(cnt_sec), 1);
    send_model(8'h7E, 13'b0_0000_1000_0001);
    @(posedge clk); #1;
    clr_cnt = 1'b1;
    @(posedge clk); #1;
    clr_cnt = 1'b0;
    chk("clr_with_ded_cnt", 32'(cnt_ded), 1);
    chk("clr_with_ded_log", {27'd0, log_vld, log_syn}, {27'd0, 1'b1, 4'(1 ^ 8)});
    drain();

    // Reset with both stages full.
    ordy = 1'b0;
    send_model(8'h11, rmask(1));
    send_model(8'h22, '0);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_ovld", 32'(ovld), 0);
    chk("rst_mid_cnt", {24'd0, cnt_sec, cnt_ded}, 0);
    chk("rst_mid_log", {27'd0, log_vld, log_syn}, 0);
    ordy = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    send(13'h0A27, mk(8'hA5, 1'b0, 1'b0, 4'd0));
    drain();
    chk("leftover", 32'(q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
